instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Requester side of the instruction-memory read interface. Owns the program counter and presents a word-aligned fetch address every cycle. It captures the memory's registered, 1-cycle-latency instruction word and delivers {instr, pc} pairs to decode over a valid/ready handshake. Provides a 1-entry skid buffer for decode back-pressure and handles branch/jump redirects from execute with flush of in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and fetch address
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  fetch address to instruction memory (= pc_f register, word-aligned)
imem_instr  input  32  instruction word from memory; valid one cycle after the address is presented
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
out_ready  input  1  decode accepts this cycle
out_instr  output  32  fetched instruction
out_pc  output  ADDR_W  address of out_instr

Behaviour:
- Reset is a synchronous clk edge with reset=1. It sets pc_f=RESET_PC, v_d=0, pc_d=0, skid_valid=0, skid_instr=0, skid_pc=0. A reset in mid-operation discards everything in flight. Outputs in the cycle after reset: out_valid=0, imem_addr=RESET_PC.
- State: pc_f (address presented now), pc_d/v_d (address presented last cycle; v_d=1 means imem_instr is a live response for pc_d), skid_valid/skid_instr/skid_pc.
- imem_addr = pc_f always. There is no combinational path from out_ready or redirect to imem_addr.
- Output mux: if skid_valid, out = {skid_instr, skid_pc}; else out = {imem_instr, pc_d}.
- out_valid = !redirect_valid && (skid_valid || v_d).
- Transfer occurs when out_valid && out_ready.
- issue = !redirect_valid && (skid_valid ? out_ready : !(v_d && !out_ready)).
- When issue=1: pc_d<=pc_f, v_d<=1, pc_f<=pc_f+4. The add is modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0x0.
- When issue=0 and no redirect: pc_f holds, v_d<=0.
- Skid load: if !skid_valid && v_d && !out_ready && !redirect_valid, then skid <= {imem_instr, pc_d} and skid_valid<=1.
- Skid drain: if skid_valid && out_ready && !redirect_valid, then skid_valid<=0. The same cycle issues pc_f, so there is no bubble after stall release.
- Invariant: skid_valid=1 implies v_d=0. At most one instruction is buffered.
- Redirect has priority over everything except reset. In the redirect cycle:
  - out_valid=0 and no transfer.
  - pc_f <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - v_d<=0, skid_valid<=0.
  - The target is presented at t+1 and out_valid rises at t+2 (2 bubble cycles).
- Ordering: delivered pcs are strictly sequential (+4) between redirects. There are no duplicates and no drops under any out_ready pattern.
- Steady state with out_ready=1: one instruction per cycle.

Test Plan:
- Preload memory word i = 32'h1000_0000+i. Release reset with out_ready=1 → out_valid=0 in cycle 0, first valid in cycle 1 with out_pc=0x0/out_instr=0x1000_0000, then 0x4/0x1000_0001 and 0x8/0x1000_0002 on consecutive cycles.
- Drop out_ready for 3 cycles while out_pc=0x8 → out_pc=0x8/instr=0x1000_0002 held stable with out_valid=1 for 4 cycles. The cycle after acceptance shows 0xC/0x1000_0003, with no gap, skip, or duplicate.
- Pulse redirect_valid with redirect_pc=0x20 while out_pc=0x4 → out_valid=0 that cycle and the next. Then 0x20/0x1000_0008, followed by 0x24/0x1000_0009.
- Redirect to 0x30 while skid_valid=1 and out_ready=0 → buffered instruction never delivered; first valid out_pc=0x30 two cycles later.
- Redirect to misaligned 0x22 → imem_addr=0x20 next cycle, out_pc=0x20. Redirect to 0xFFFF_FFFC → delivered pcs are 0xFFFF_FFFC then 0x0.
- Assert reset for 1 cycle during a stall with the skid full → out_valid=0 the next cycle, imem_addr=RESET_PC, delivery restarts at out_pc=0x0 one cycle later.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives a word-aligned
// fetch address every cycle, captures the 1-cycle-latency instruction word
// and hands {instr, pc} pairs to decode over a valid/ready handshake.
// A 1-entry skid buffer absorbs decode back-pressure; execute redirects
// flush everything in flight.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset          synchronous active-high reset
//   imem_addr      fetch address to instruction memory (pc_f register)
//   imem_instr     instruction word, valid one cycle after its address
//   redirect_valid execute requests a PC change this cycle
//   redirect_pc    redirect target, low two bits ignored
//   out_valid      out_instr/out_pc hold a valid fetched instruction
//   out_ready      decode accepts this cycle
//   out_instr      fetched instruction
//   out_pc         address of out_instr
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned INSTR_W = 32;

    logic [ADDR_W-1:0]  pc_f_q, pc_f_d;
    logic [ADDR_W-1:0]  pc_d_q, pc_d_d;
    logic               v_d_q, v_d_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic               issue;

    // Fetch address is the PC register only; no path from ready/redirect.
    assign imem_addr = pc_f_q;

    // Output mux: buffered instruction wins over the live memory response.
    always_comb begin
        out_valid = !redirect_valid && (skid_valid_q || v_d_q);
        out_instr = skid_valid_q ? skid_instr_q : imem_instr;
        out_pc    = skid_valid_q ? skid_pc_q : pc_d_q;
    end

    // Next-state: redirect flushes; otherwise issue a new fetch only when
    // the response it produces next cycle is guaranteed somewhere to land.
    always_comb begin
        pc_f_d       = pc_f_q;
        pc_d_d       = pc_d_q;
        v_d_d        = v_d_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        issue        = 1'b0;

        if (redirect_valid) begin
            pc_f_d       = redirect_pc & ~ADDR_W'(3);
            v_d_d        = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            issue = skid_valid_q ? out_ready : !(v_d_q && !out_ready);

            if (issue) begin
                pc_d_d = pc_f_q;
                v_d_d  = 1'b1;
                pc_f_d = pc_f_q + ADDR_W'(4);
            end else begin
                v_d_d = 1'b0;
            end

            // Stalled live response moves into the skid buffer.
            if (!skid_valid_q && v_d_q && !out_ready) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_instr;
                skid_pc_d    = pc_d_q;
            end

            // Drain coincides with a fresh issue, so no bubble follows.
            if (skid_valid_q && out_ready) begin
                skid_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q       <= RESET_PC;
            pc_d_q       <= '0;
            v_d_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            v_d_q        <= v_d_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule
